// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle (8-bit address / 8-bit data) between the APB master and a register-file completer.
interface apb_regfile_slave_if;
  logic       pselx;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB completer serving a byte register file with a read-only ID at address 0,
// programmable wait states, and pslverr on out-of-range or ID-register writes.
module apb_regfile_slave #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic                pclk,
  input  logic                presetn,
  apb_regfile_slave_if.slave  apb
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [8:0]  DEPTH_EXT = 9'(DEPTH);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    addr_q;
  logic [7:0]    wdata_q;
  logic          write_q;
  logic [7:0]    mem [DEPTH];

  // Error when the address is past the file or a write targets the ID register.
  function automatic logic is_err(input logic [7:0] a, input logic w);
    return ({1'b0, a} >= DEPTH_EXT) || (w && (a == 8'd0));
  endfunction

  function automatic logic [AW-1:0] idx(input logic [7:0] a);
    return a[AW-1:0];
  endfunction

  // Read data presented on the completing cycle; zero for writes and errors.
  function automatic logic [7:0] rd_val(input logic [7:0] a, input logic w);
    logic [7:0] v;
    v = 8'd0;
    if (!w && !is_err(a, w)) begin
      if (a == 8'd0) v = ID_VALUE;
      else           v = mem[idx(a)];
    end
    return v;
  endfunction

  // Transfer sequencing, registered response and register-file update.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      apb.prdata  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      apb.prdata  <= '0;
      case (state)
        S_IDLE: begin
          // Only a setup phase starts a transfer; a lone access phase is ignored.
          if (apb.pselx && !apb.penable) begin
            addr_q  <= apb.paddr;
            wdata_q <= apb.pwdata;
            write_q <= apb.pwrite;
            cnt     <= WAIT_LOAD;
            if (WAIT_LOAD == '0) begin
              state       <= S_DONE;
              apb.pready  <= 1'b1;
              apb.pslverr <= is_err(apb.paddr, apb.pwrite);
              apb.prdata  <= rd_val(apb.paddr, apb.pwrite);
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!apb.pselx) begin
            state <= S_IDLE;
          end else if (apb.penable) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state       <= S_DONE;
              apb.pready  <= 1'b1;
              apb.pslverr <= is_err(addr_q, write_q);
              apb.prdata  <= rd_val(addr_q, write_q);
            end
          end
        end
        S_DONE: begin
          if (write_q && !is_err(addr_q, 1'b1)) begin
            mem[idx(addr_q)] <= wdata_q;
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance,
// driven by directed transfers and checked every cycle against a transaction-level model.
module tb_apb_regfile_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn    [2];
  logic       d_psel  [2];
  logic       d_pen   [2];
  logic       d_pw    [2];
  logic [7:0] d_addr  [2];
  logic [7:0] d_wdata [2];

  apb_regfile_slave_if bus_a ();
  apb_regfile_slave_if bus_b ();

  assign bus_a.pselx   = d_psel[0];
  assign bus_a.penable = d_pen[0];
  assign bus_a.pwrite  = d_pw[0];
  assign bus_a.paddr   = d_addr[0];
  assign bus_a.pwdata  = d_wdata[0];
  assign bus_b.pselx   = d_psel[1];
  assign bus_b.penable = d_pen[1];
  assign bus_b.pwrite  = d_pw[1];
  assign bus_b.paddr   = d_addr[1];
  assign bus_b.pwdata  = d_wdata[1];

  apb_regfile_slave #(.DEPTH(32), .WAIT_CYCLES(2), .ID_VALUE(8'hA5)) dut_a (
    .pclk(clk), .presetn(rstn[0]), .apb(bus_a.slave)
  );
  apb_regfile_slave #(.DEPTH(32), .WAIT_CYCLES(0), .ID_VALUE(8'hA5)) dut_b (
    .pclk(clk), .presetn(rstn[1]), .apb(bus_b.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: register contents and the response each instance must show in the coming cycle.
  logic [7:0] model_mem [2][256];
  logic       exp_rdy   [2];
  logic       exp_err   [2];
  logic [7:0] exp_data  [2];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int waits_of(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  function automatic bit m_err(input int a, input bit w);
    return (a >= 32) || (w && a == 0);
  endfunction

  function automatic logic [7:0] m_rd(input int s, input int a, input bit w);
    if (w || m_err(a, w)) return 8'h00;
    if (a == 0) return 8'hA5;
    return model_mem[s][a];
  endfunction

  function automatic logic get_rdy(input int s);
    return (s == 0) ? bus_a.pready : bus_b.pready;
  endfunction
  function automatic logic get_err(input int s);
    return (s == 0) ? bus_a.pslverr : bus_b.pslverr;
  endfunction
  function automatic logic [7:0] get_data(input int s);
    return (s == 0) ? bus_a.prdata : bus_b.prdata;
  endfunction

  task automatic set_exp(input int s, input logic r, input logic e, input logic [7:0] d);
    exp_rdy[s]  = r;
    exp_err[s]  = e;
    exp_data[s] = d;
  endtask

  task automatic clear_model(input int s);
    for (int i = 0; i < 256; i++) model_mem[s][i] = 8'h00;
  endtask

  // Per-cycle compare of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        check8(s == 0 ? "pready_a"  : "pready_b",  8'(get_rdy(s)),  8'(exp_rdy[s]));
        check8(s == 0 ? "pslverr_a" : "pslverr_b", 8'(get_err(s)),  8'(exp_err[s]));
        check8(s == 0 ? "prdata_a"  : "prdata_b",  get_data(s),     exp_data[s]);
      end
    end
  end

  task automatic idle(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      d_psel[s] = 1'b0;
      d_pen[s]  = 1'b0;
      set_exp(s, 1'b0, 1'b0, 8'h00);
    end
  endtask

  // One APB transfer. abort_at / rst_at name the cycle (0 = setup, k = access cycle k)
  // in which pselx drops or presetn is pulled low; -1 disables. Response sampled on the pready cycle.
  task automatic xfer(input int s, input bit w, input logic [7:0] a, input logic [7:0] wd,
                      input int abort_at, input int rst_at,
                      output logic gr, output logic ge, output logic [7:0] gd);
    int nw;
    nw = waits_of(s);
    gr = 1'b0; ge = 1'b0; gd = 8'h00;
    for (int j = 0; j <= nw; j++) begin
      @(negedge clk);
      if (j == rst_at) begin
        rstn[s]   = 1'b0;
        d_pen[s]  = 1'b1;
        set_exp(s, 1'b0, 1'b0, 8'h00);
        clear_model(s);
        @(negedge clk);
        rstn[s]   = 1'b1;
        d_psel[s] = 1'b0;
        d_pen[s]  = 1'b0;
        return;
      end
      if (j == abort_at) begin
        d_psel[s] = 1'b0;
        d_pen[s]  = 1'b0;
        set_exp(s, 1'b0, 1'b0, 8'h00);
        return;
      end
      d_psel[s]  = 1'b1;
      d_pen[s]   = (j != 0);
      // After setup the address/data/direction are scrambled; the latched copies must win.
      d_pw[s]    = (j == 0) ? w : ~w;
      d_addr[s]  = (j == 0) ? a : ~a;
      d_wdata[s] = (j == 0) ? wd : ~wd;
      if (j == nw) set_exp(s, 1'b1, 1'(m_err(int'(a), w)), m_rd(s, int'(a), w));
      else         set_exp(s, 1'b0, 1'b0, 8'h00);
    end
    @(negedge clk);
    gr = get_rdy(s);
    ge = get_err(s);
    gd = get_data(s);
    d_psel[s] = 1'b1;
    d_pen[s]  = 1'b1;
    set_exp(s, 1'b0, 1'b0, 8'h00);
    if (w && !m_err(int'(a), w)) model_mem[s][a] = wd;
  endtask

  initial begin
    logic       gr;
    logic       ge;
    logic [7:0] gd;
    for (int s = 0; s < 2; s++) begin
      rstn[s] = 1'b0; d_psel[s] = 1'b0; d_pen[s] = 1'b0; d_pw[s] = 1'b0;
      d_addr[s] = 8'h00; d_wdata[s] = 8'h00;
      clear_model(s);
      set_exp(s, 1'b0, 1'b0, 8'h00);
    end
    repeat (2) @(negedge clk);
    check8("rst_pready",  8'(bus_a.pready),  8'h00);
    check8("rst_pslverr", 8'(bus_a.pslverr), 8'h00);
    check8("rst_prdata",  bus_a.prdata,      8'h00);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    chk_en  = 1'b1;
    idle(0, 2);

    // Write then read back addr 5.
    xfer(0, 1'b1, 8'd5, 8'h3C, -1, -1, gr, ge, gd);
    check8("wr5_ready", 8'(gr), 8'h01);
    check8("wr5_err",   8'(ge), 8'h00);
    xfer(0, 1'b0, 8'd5, 8'h00, -1, -1, gr, ge, gd);
    check8("rd5_data", gd, 8'h3C);

    // ID register: readable, write rejected, value unchanged.
    xfer(0, 1'b0, 8'd0, 8'h00, -1, -1, gr, ge, gd);
    check8("rd0_data", gd, 8'hA5);
    check8("rd0_err",  8'(ge), 8'h00);
    xfer(0, 1'b1, 8'd0, 8'hFF, -1, -1, gr, ge, gd);
    check8("wr0_err", 8'(ge), 8'h01);
    xfer(0, 1'b0, 8'd0, 8'h00, -1, -1, gr, ge, gd);
    check8("rd0_again", gd, 8'hA5);

    // Out-of-range and boundary addresses.
    xfer(0, 1'b1, 8'd40, 8'h11, -1, -1, gr, ge, gd);
    check8("wr40_err", 8'(ge), 8'h01);
    xfer(0, 1'b0, 8'd40, 8'h00, -1, -1, gr, ge, gd);
    check8("rd40_err",  8'(ge), 8'h01);
    check8("rd40_data", gd, 8'h00);
    xfer(0, 1'b1, 8'd31, 8'hE7, -1, -1, gr, ge, gd);
    xfer(0, 1'b0, 8'd31, 8'h00, -1, -1, gr, ge, gd);
    check8("rd31_data", gd, 8'hE7);
    xfer(0, 1'b0, 8'd32, 8'h00, -1, -1, gr, ge, gd);
    check8("rd32_err", 8'(ge), 8'h01);
    xfer(0, 1'b0, 8'd8, 8'h00, -1, -1, gr, ge, gd);
    check8("rd8_data", gd, 8'h08 ^ 8'h08);

    // Access phase with no preceding setup is ignored.
    @(negedge clk);
    d_psel[0] = 1'b1; d_pen[0] = 1'b1; d_pw[0] = 1'b1; d_addr[0] = 8'd4; d_wdata[0] = 8'h44;
    set_exp(0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    set_exp(0, 1'b0, 1'b0, 8'h00);
    idle(0, 1);
    xfer(0, 1'b0, 8'd4, 8'h00, -1, -1, gr, ge, gd);
    check8("orphan_rd4", gd, 8'h00);

    // Abort after access cycle 1: no write, next transfer normal.
    xfer(0, 1'b1, 8'd3, 8'h77, 2, -1, gr, ge, gd);
    idle(0, 1);
    xfer(0, 1'b0, 8'd3, 8'h00, -1, -1, gr, ge, gd);
    check8("abort_rd3", gd, 8'h00);
    xfer(0, 1'b1, 8'd9, 8'h5A, -1, -1, gr, ge, gd);
    xfer(0, 1'b0, 8'd9, 8'h00, -1, -1, gr, ge, gd);
    check8("after_abort_rd9", gd, 8'h5A);

    // Reset during access cycle 2: dropped write, register file cleared.
    xfer(0, 1'b1, 8'd7, 8'h99, -1, 2, gr, ge, gd);
    idle(0, 1);
    xfer(0, 1'b0, 8'd7, 8'h00, -1, -1, gr, ge, gd);
    check8("rst_rd7", gd, 8'h00);
    xfer(0, 1'b0, 8'd5, 8'h00, -1, -1, gr, ge, gd);
    check8("rst_rd5", gd, 8'h00);
    idle(0, 1);

    // Zero-wait instance: back-to-back writes then reads.
    xfer(1, 1'b1, 8'd1, 8'hC3, -1, -1, gr, ge, gd);
    check8("b_wr1_ready", 8'(gr), 8'h01);
    xfer(1, 1'b1, 8'd2, 8'h3D, -1, -1, gr, ge, gd);
    check8("b_wr2_ready", 8'(gr), 8'h01);
    xfer(1, 1'b0, 8'd1, 8'h00, -1, -1, gr, ge, gd);
    check8("b_rd1", gd, 8'hC3);
    xfer(1, 1'b0, 8'd2, 8'h00, -1, -1, gr, ge, gd);
    check8("b_rd2", gd, 8'h3D);
    xfer(1, 1'b0, 8'd0, 8'h00, -1, -1, gr, ge, gd);
    check8("b_rd0", gd, 8'hA5);
    idle(1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
